// File: rtl/router_core_param.sv
// Ring router core: RX classification (drop / deliver / forward), forward FIFO, one-entry local
// injection and an anti-starvation TX arbiter. Define ROUTER_BCAST_EN to deliver-and-forward dst=all-ones.
module router_core_param #(
  parameter int ADDR_W     = 4,
  parameter int TYPE_W     = 3,
  parameter int PAYLOAD_W  = 24,
  parameter int NODE_ADDR  = 0,
  parameter int FWD_DEPTH  = 4,
  parameter int STARVE_LIM = 3,
  localparam int FLIT_W    = 2*ADDR_W + TYPE_W + PAYLOAD_W,
  localparam int PKT_W     = ADDR_W + TYPE_W + PAYLOAD_W
) (
  input  logic              Clk_R,
  input  logic              Rst_n,
  input  logic [FLIT_W-1:0] RX_Data,
  input  logic              RX_Data_Valid,
  output logic              RX_Data_Ready,
  output logic [FLIT_W-1:0] TX_Data,
  output logic              TX_Data_Valid,
  input  logic              TX_Data_Ready,
  input  logic [PKT_W-1:0]  Packet_From_Node,
  input  logic              Packet_From_Node_Valid,
  output logic              Core_Load_Ack,
  output logic [PKT_W-1:0]  Packet_To_Node,
  output logic              Packet_To_Node_Valid,
  input  logic              Packet_To_Node_Ready
);

  localparam int PTR_W = $clog2(FWD_DEPTH) + 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W-1:0] SELF     = ADDR_W'(NODE_ADDR);
  localparam logic [CNT_W-1:0]  LIM      = CNT_W'(STARVE_LIM);
  localparam logic [PTR_W-1:0]  WRAP_BIT = {1'b1, {(PTR_W-1){1'b0}}};
`ifdef ROUTER_BCAST_EN
  localparam logic [ADDR_W-1:0] BCAST    = '1;
`endif

  logic [FLIT_W-1:0] fifo_mem [FWD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic              inj_full, inj_load;
  logic [FLIT_W-1:0] inj_flit;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_hit;

  logic [ADDR_W-1:0] rx_dst, rx_src;
  logic              rx_accept, rx_deliver, rx_fwd;
  logic              tx_loadable, sel_fifo, sel_inj;

  assign rx_dst = RX_Data[FLIT_W-1 -: ADDR_W];
  assign rx_src = RX_Data[FLIT_W-ADDR_W-1 -: ADDR_W];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == WRAP_BIT);

  // Ready is built from registered state only; held low throughout reset.
  assign RX_Data_Ready = Rst_n && !fifo_full && !Packet_To_Node_Valid;
  assign rx_accept     = RX_Data_Valid && RX_Data_Ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_deliver = 1'b0;
    rx_fwd     = 1'b0;
    if (rx_src != SELF) begin
`ifdef ROUTER_BCAST_EN
      if (rx_dst == BCAST) begin
        rx_deliver = 1'b1;
        rx_fwd     = 1'b1;
      end else
`endif
      if (rx_dst == SELF) rx_deliver = 1'b1;
      else                rx_fwd     = 1'b1;
    end
  end

  assign fifo_push = rx_accept && rx_fwd;

  // TX arbitration: FIFO wins unless the pending injection has waited STARVE_LIM sends.
  assign tx_loadable = !TX_Data_Valid || TX_Data_Ready;
  assign starve_hit  = (starve_cnt == LIM);
  assign sel_inj     = tx_loadable && inj_full && (fifo_empty || starve_hit);
  assign sel_fifo    = tx_loadable && !fifo_empty && !sel_inj;
  assign fifo_pop    = sel_fifo;
  assign inj_load    = !inj_full && Packet_From_Node_Valid;

  // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge Clk_R) begin
    if (fifo_push) fifo_mem[wr_ptr[PTR_W-2:0]] <= RX_Data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      Packet_To_Node_Valid <= 1'b0;
      Packet_To_Node       <= '0;
    end else if (rx_accept && rx_deliver) begin
      Packet_To_Node_Valid <= 1'b1;
      Packet_To_Node       <= {RX_Data[PAYLOAD_W +: TYPE_W], rx_src, RX_Data[PAYLOAD_W-1:0]};
    end else if (Packet_To_Node_Ready) begin
      Packet_To_Node_Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      inj_full      <= 1'b0;
      inj_flit      <= '0;
      Core_Load_Ack <= 1'b0;
    end else begin
      Core_Load_Ack <= inj_load;
      if (sel_inj) begin
        inj_full <= 1'b0;
      end else if (inj_load) begin
        inj_full <= 1'b1;
        inj_flit <= {Packet_From_Node[PKT_W-1 -: ADDR_W], SELF,
                     Packet_From_Node[TYPE_W+PAYLOAD_W-1:0]};
      end
    end
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_cnt <= '0;
    end else if (!inj_full || sel_inj) begin
      starve_cnt <= '0;
    end else if (sel_fifo && !starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      TX_Data_Valid <= 1'b0;
      TX_Data       <= '0;
    end else if (tx_loadable) begin
      TX_Data_Valid <= sel_fifo || sel_inj;
      if (sel_fifo)     TX_Data <= fifo_mem[rd_ptr[PTR_W-2:0]];
      else if (sel_inj) TX_Data <= inj_flit;
    end
  end

endmodule

// File: tb/tb_router_core_param.sv
// Directed bench for router_core_param (NODE_ADDR=2): reset, delivery, source removal,
// forward backpressure, injection latency, anti-starvation, broadcast and mid-stream reset.
module tb_router_core_param;

  localparam int ADDR_W = 4, TYPE_W = 3, PAYLOAD_W = 24;
  localparam int NODE = 2, DEPTH = 4, LIM = 3;
  localparam int FLIT_W = 2*ADDR_W + TYPE_W + PAYLOAD_W;
  localparam int PKT_W  = ADDR_W + TYPE_W + PAYLOAD_W;

  logic              Clk_R, Rst_n;
  logic [FLIT_W-1:0] RX_Data, TX_Data;
  logic              RX_Data_Valid, RX_Data_Ready, TX_Data_Valid, TX_Data_Ready;
  logic [PKT_W-1:0]  Packet_From_Node, Packet_To_Node;
  logic              Packet_From_Node_Valid, Core_Load_Ack;
  logic              Packet_To_Node_Valid, Packet_To_Node_Ready;

  int vectors = 0;
  int miscompares = 0;

  router_core_param #(
    .ADDR_W(ADDR_W), .TYPE_W(TYPE_W), .PAYLOAD_W(PAYLOAD_W),
    .NODE_ADDR(NODE), .FWD_DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .Clk_R(Clk_R), .Rst_n(Rst_n),
    .RX_Data(RX_Data), .RX_Data_Valid(RX_Data_Valid), .RX_Data_Ready(RX_Data_Ready),
    .TX_Data(TX_Data), .TX_Data_Valid(TX_Data_Valid), .TX_Data_Ready(TX_Data_Ready),
    .Packet_From_Node(Packet_From_Node), .Packet_From_Node_Valid(Packet_From_Node_Valid),
    .Core_Load_Ack(Core_Load_Ack),
    .Packet_To_Node(Packet_To_Node), .Packet_To_Node_Valid(Packet_To_Node_Valid),
    .Packet_To_Node_Ready(Packet_To_Node_Ready)
  );

  initial begin
    Clk_R = 1'b0;
    forever #5 Clk_R = ~Clk_R;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_R);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [3:0] dst, input logic [3:0] src,
                                                input logic [2:0] typ, input logic [23:0] pay);
    return {dst, src, typ, pay};
  endfunction

  logic [FLIT_W-1:0] fwd [6];
  logic [FLIT_W-1:0] sv_exp [6];
  logic [FLIT_W-1:0] bc;
  int   acc, out_idx, gaps, ack_cnt;
  logic go;

  initial begin
    Rst_n = 1'b0;
    RX_Data = '0; RX_Data_Valid = 1'b0; TX_Data_Ready = 1'b0;
    Packet_From_Node = '0; Packet_From_Node_Valid = 1'b0; Packet_To_Node_Ready = 1'b0;
    repeat (2) tick();

    check("rst_tx_valid", TX_Data_Valid, 0);
    check("rst_tx_data", TX_Data, 0);
    check("rst_rx_ready", RX_Data_Ready, 0);
    check("rst_dlv_valid", Packet_To_Node_Valid, 0);
    check("rst_ack", Core_Load_Ack, 0);
    Rst_n = 1'b1;
    #1;
    check("post_rst_rx_ready", RX_Data_Ready, 1);
    check("post_rst_tx_valid", TX_Data_Valid, 0);
    tick();

    // Delivery held while the node is not ready; RX blocked meanwhile.
    RX_Data = mk_flit(4'd2, 4'd5, 3'd1, 24'hABCDEF);
    RX_Data_Valid = 1'b1;
    tick();
    RX_Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("dlv_valid", Packet_To_Node_Valid, 1);
      check("dlv_data", Packet_To_Node, {3'd1, 4'd5, 24'hABCDEF});
      check("dlv_rx_block", RX_Data_Ready, 0);
      tick();
    end
    Packet_To_Node_Ready = 1'b1;
    tick();
    Packet_To_Node_Ready = 1'b0;
    check("dlv_clear", Packet_To_Node_Valid, 0);
    check("dlv_rx_free", RX_Data_Ready, 1);
    check("dlv_no_tx", TX_Data_Valid, 0);

    // Source removal: src == NODE is swallowed.
    TX_Data_Ready = 1'b1;
    RX_Data = mk_flit(4'd7, 4'd2, 3'd2, 24'h00D00D);
    RX_Data_Valid = 1'b1;
    tick();
    RX_Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_tx_idle", TX_Data_Valid, 0);
      check("drop_dlv_idle", Packet_To_Node_Valid, 0);
      tick();
    end

    // Forward backpressure: 4 FIFO entries + 1 output register before RX stalls.
    TX_Data_Ready = 1'b0;
    for (int i = 0; i < 6; i++) fwd[i] = mk_flit(4'd7, 4'd3, 3'd4, 24'(32'h0A0000 + i));
    acc = 0;
    for (int c = 0; c < 12 && acc < 6; c++) begin
      RX_Data = fwd[acc];
      RX_Data_Valid = 1'b1;
      if (!RX_Data_Ready) break;
      tick();
      acc++;
    end
    RX_Data_Valid = (acc < 6);
    check("bp_accept_count", acc, 5);
    repeat (2) tick();
    check("bp_rx_blocked", RX_Data_Ready, 0);
    check("bp_tx_head_valid", TX_Data_Valid, 1);
    check("bp_tx_head", TX_Data, fwd[0]);

    TX_Data_Ready = 1'b1;
    out_idx = 0;
    gaps = 0;
    for (int c = 0; c < 20 && out_idx < 6; c++) begin
      if (TX_Data_Valid) begin
        check($sformatf("bp_order%0d", out_idx), TX_Data, fwd[out_idx]);
        out_idx++;
      end else begin
        gaps++;
      end
      go = RX_Data_Valid && RX_Data_Ready;
      tick();
      if (go) acc++;
      RX_Data_Valid = (acc < 6);
      if (acc < 6) RX_Data = fwd[acc];
    end
    check("bp_all_out", out_idx, 6);
    check("bp_no_bubble", gaps, 0);
    check("bp_drained", TX_Data_Valid, 0);

    // Injection into an idle core: ack cycle N, TX valid at N+1.
    Packet_From_Node = {4'd9, 3'd6, 24'h123456};
    Packet_From_Node_Valid = 1'b1;
    check("inj_ack_idle", Core_Load_Ack, 0);
    tick();
    Packet_From_Node_Valid = 1'b0;
    check("inj_ack_pulse", Core_Load_Ack, 1);
    check("inj_tx_not_yet", TX_Data_Valid, 0);
    tick();
    check("inj_ack_low", Core_Load_Ack, 0);
    check("inj_tx_valid", TX_Data_Valid, 1);
    check("inj_tx_data", TX_Data, mk_flit(4'd9, 4'd2, 3'd6, 24'h123456));
    tick();
    check("inj_tx_done", TX_Data_Valid, 0);

    // Anti-starvation: output reg holds sv0 when the inject arrives, FIFO holds sv1..sv4.
    // Expected wire order: sv0, then 3 forwarded (sv1..sv3), then the inject, then sv4.
    TX_Data_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RX_Data = mk_flit(4'd8, 4'd4, 3'd3, 24'(32'h0B0000 + i));
      RX_Data_Valid = 1'b1;
      check("sv_fill_ready", RX_Data_Ready, 1);
      tick();
    end
    RX_Data_Valid = 1'b0;
    check("sv_full", RX_Data_Ready, 0);
    for (int i = 0; i < 4; i++) sv_exp[i] = mk_flit(4'd8, 4'd4, 3'd3, 24'(32'h0B0000 + i));
    sv_exp[4] = mk_flit(4'd12, 4'd2, 3'd5, 24'h5A5A5A);
    sv_exp[5] = mk_flit(4'd8, 4'd4, 3'd3, 24'h0B0004);

    Packet_From_Node = {4'd12, 3'd5, 24'h5A5A5A};
    Packet_From_Node_Valid = 1'b1;
    tick();
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (Core_Load_Ack) ack_cnt++;
      tick();
    end
    Packet_From_Node_Valid = 1'b0;
    check("sv_ack_single", ack_cnt, 1);

    TX_Data_Ready = 1'b1;
    out_idx = 0;
    for (int c = 0; c < 20 && out_idx < 6; c++) begin
      if (TX_Data_Valid) begin
        check($sformatf("sv_order%0d", out_idx), TX_Data, sv_exp[out_idx]);
        out_idx++;
      end
      tick();
    end
    check("sv_all_out", out_idx, 6);
    check("sv_drained", TX_Data_Valid, 0);

    // Broadcast destination: delivered and forwarded with ROUTER_BCAST_EN, forwarded only without.
    bc = mk_flit(4'hF, 4'd5, 3'd3, 24'h00BCA5);
    RX_Data = bc;
    RX_Data_Valid = 1'b1;
    tick();
    RX_Data_Valid = 1'b0;
`ifdef ROUTER_BCAST_EN
    check("bc_dlv_valid", Packet_To_Node_Valid, 1);
    check("bc_dlv_data", Packet_To_Node, {3'd3, 4'd5, 24'h00BCA5});
`else
    check("bc_dlv_valid", Packet_To_Node_Valid, 0);
`endif
    check("bc_tx_early", TX_Data_Valid, 0);
    tick();
    check("bc_tx_valid", TX_Data_Valid, 1);
    check("bc_tx_data", TX_Data, bc);
    Packet_To_Node_Ready = 1'b1;
    tick();
    Packet_To_Node_Ready = 1'b0;
    check("bc_dlv_clear", Packet_To_Node_Valid, 0);
    check("bc_tx_done", TX_Data_Valid, 0);

    // Asynchronous reset in the middle of a stalled transfer.
    TX_Data_Ready = 1'b0;
    RX_Data = mk_flit(4'd6, 4'd1, 3'd7, 24'hFEDCBA);
    RX_Data_Valid = 1'b1;
    tick();
    RX_Data_Valid = 1'b0;
    tick();
    check("mid_tx_valid", TX_Data_Valid, 1);
    Packet_From_Node = {4'd3, 3'd2, 24'h0F0F0F};
    Packet_From_Node_Valid = 1'b1;
    tick();
    Packet_From_Node_Valid = 1'b0;
    check("mid_ack", Core_Load_Ack, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", TX_Data_Valid, 0);
    check("mid_rst_tx_data", TX_Data, 0);
    check("mid_rst_ack", Core_Load_Ack, 0);
    check("mid_rst_dlv", Packet_To_Node_Valid, 0);
    check("mid_rst_dlv_data", Packet_To_Node, 0);
    check("mid_rst_rx_ready", RX_Data_Ready, 0);
    tick();
    Rst_n = 1'b1;
    TX_Data_Ready = 1'b1;
    #1;
    check("mid_rel_rx_ready", RX_Data_Ready, 1);
    check("mid_rel_tx_valid", TX_Data_Valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_discard", TX_Data_Valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_core_param.md
Name: router_core_param

Overview:
- Parametrised next-generation ring router core for the token-based router.
- Accepts flits from the upstream ring link (RX) and classifies each one by destination and source address:
  - flits addressed to this node are delivered to the local node;
  - flits that have returned to their own source are removed;
  - all other flits are buffered in a forward FIFO and re-sent downstream (TX).
- Local node packets are injected into the TX stream. An anti-starvation arbiter shares TX between forwarded and injected traffic.

Parameters:
- ADDR_W, 4, node address width
- TYPE_W, 3, flit type field width
- PAYLOAD_W, 24, payload width
- NODE_ADDR, 0, this router's ring address
- FWD_DEPTH, 4, forward FIFO depth; must be a power of two, ≥2
- STARVE_LIM, 3, maximum consecutive forwarded flits sent while an injection is pending; ≥1
- Derived: FLIT_W = 2*ADDR_W+TYPE_W+PAYLOAD_W. Flit layout is {dst, src, type, payload}, dst in the MSBs.

Ports:
- Clk_R  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- RX_Data  in  FLIT_W  upstream flit
- RX_Data_Valid  in  1  upstream flit valid
- RX_Data_Ready  out  1  core can accept an RX flit
- TX_Data  out  FLIT_W  downstream flit, registered
- TX_Data_Valid  out  1  downstream flit valid, registered
- TX_Data_Ready  in  1  downstream accepts
- Packet_From_Node  in  ADDR_W+TYPE_W+PAYLOAD_W  {dst, type, payload} from the local node
- Packet_From_Node_Valid  in  1  node packet valid
- Core_Load_Ack  out  1  one-cycle pulse: node packet captured
- Packet_To_Node  out  TYPE_W+ADDR_W+PAYLOAD_W  {type, src, payload} delivered to the node, registered
- Packet_To_Node_Valid  out  1  delivery valid
- Packet_To_Node_Ready  in  1  node consumes the delivery

Behaviour:
- Reset: all outputs go to 0, the FIFO is empty, the inject and delivery registers are empty, and the starvation count is 0. Reset applies asynchronously mid-transfer, and any in-flight flits are discarded.
- RX_Data_Ready = !fifo_full && !deliver_full. It depends only on registered state, never on RX_Data. An RX flit is accepted when RX_Data_Valid && RX_Data_Ready.
- Classification of an accepted flit, in priority order:
  - src==NODE_ADDR → drop. The flit is consumed and nothing is emitted.
  - dst==NODE_ADDR → delivery register loaded. Packet_To_Node_Valid rises the next cycle and holds until Packet_To_Node_Ready.
  - Otherwise → push to the forward FIFO.
- Delivery register: a simultaneous drain and new accept in the same cycle is not allowed, because RX_Data_Ready is low while the register is full. This means one bubble per delivered flit.
- Injection register (1 entry): it captures Packet_From_Node when it is empty and Packet_From_Node_Valid is high. Core_Load_Ack pulses high for exactly that one cycle. The TX flit is formed as {dst, NODE_ADDR, type, payload}.
- TX output register:
  - It is loaded when empty, or when TX_Data_Valid && TX_Data_Ready in the same cycle (back-to-back, no bubble).
  - TX_Data and TX_Data_Valid are held stable while TX_Data_Ready is low.
- TX source selection, evaluated only when the output register is loadable:
  - FIFO non-empty and inject empty → FIFO.
  - FIFO empty and inject full → inject.
  - Both available → FIFO, unless starve_cnt==STARVE_LIM, in which case inject is chosen.
- starve_cnt:
  - increments on each FIFO send while inject is full;
  - clears on an inject send, or whenever inject is empty;
  - saturates at STARVE_LIM.
- Latency:
  - RX accept in cycle N → FIFO entry visible at N+1 → TX_Data_Valid at N+2 if the output register is free.
  - Node capture in cycle N → TX_Data_Valid at N+1 if the FIFO is empty and the output register is free.
- FIFO:
  - Pointers are log2(FWD_DEPTH)+1 bits, with the extra MSB used for full/empty detection; wrap-around is natural.
  - Push and pop in the same cycle while full is allowed only as pop-then-push. RX_Data_Ready still reads low when full, so this case arises only from the registered full flag.
  - The FIFO never overflows or underflows. A pop is suppressed when the FIFO is empty.

Optional Feature:
- Macro ROUTER_BCAST_EN.
- When defined:
  - dst == all-ones is broadcast.
  - An accepted broadcast flit with src!=NODE_ADDR is both loaded into the delivery register and pushed to the FIFO in the same cycle.
  - RX_Data_Ready additionally requires both resources free, which the base rule already guarantees.
  - A broadcast that returns to its source is dropped as usual.
- When not defined: the all-ones address is an ordinary address, forwarded unless it equals NODE_ADDR.

Test Plan:
- Reset behaviour: assert Rst_n=0 mid-stream with TX_Data_Valid=1 → all outputs are 0 asynchronously; after release, RX_Data_Ready=1 and TX_Data_Valid=0.
- Delivery: NODE_ADDR=2, RX flit dst=2, src=5, type=1, payload=24'hABCDEF with Packet_To_Node_Ready=0 for 3 cycles:
  - Packet_To_Node={1,5,ABCDEF} is held valid and RX_Data_Ready=0;
  - after Ready, the delivery clears and RX_Data_Ready=1.
- Forward backpressure: TX_Data_Ready=0, then stream 6 flits dst=7:
  - exactly FWD_DEPTH=4 FIFO entries plus 1 output register are accepted before RX_Data_Ready=0;
  - releasing Ready emits all flits in order, one per cycle.
- Source removal: RX flit with src=NODE_ADDR → consumed, with no TX and no delivery activity.
- Anti-starvation: inject pending with the FIFO continuously non-empty → TX order is 3 forwarded flits, then the injected flit; Core_Load_Ack is a single-cycle pulse.
- With ROUTER_BCAST_EN: dst=4'hF, src=5 → delivered to the node and emitted on TX; without the macro, the same flit is forwarded only.
